carregador_8_num: RTL and testbench

CARREGADOR_8_NUM -- requirements
Module: carregador_8_num

---
 rtl/carregador_pkg.sv | 13 +
 rtl/carregador_8_num.sv | 144 ++++++++++++++
 tb/tb_carregador_8_num.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/carregador_pkg.sv
// Shared types and default parameters for the 8-value serial batch loader.
package carregador_pkg;

  localparam int unsigned N_NUM_DEF       = 8;
  localparam int unsigned WIDTH_DEF       = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  typedef enum logic {
    COLETA = 1'b0,
    CHEIO  = 1'b1
  } estado_e;

endpackage

// File: rtl/carregador_8_num.sv
// Collects N_NUM serial values into a registered batch and hands it to the sorter.
// Optional partial-batch timeout enabled by defining CARREGADOR_TIMEOUT_EN.
module carregador_8_num
  import carregador_pkg::*;
#(
  parameter int unsigned N_NUM       = N_NUM_DEF,
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ordem_i,
  input  logic             out_ack,
  output logic             ena,
  output logic             cresc_ou_decres,
  output logic [WIDTH-1:0] n1_n,
  output logic [WIDTH-1:0] n2_n,
  output logic [WIDTH-1:0] n3_n,
  output logic [WIDTH-1:0] n4_n,
  output logic [WIDTH-1:0] n5_n,
  output logic [WIDTH-1:0] n6_n,
  output logic [WIDTH-1:0] n7_n,
  output logic [WIDTH-1:0] n8_n,
  output logic             erro
);

  localparam int unsigned CNT_W = $clog2(N_NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_NUM - 1);

  if (N_NUM != 8) begin : g_bad_n_num
    $error("carregador_8_num supports only N_NUM = 8");
  end
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("carregador_8_num requires TIMEOUT_CYC > 0");
  end

  estado_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] vals_q [N_NUM];
  logic [WIDTH-1:0] vals_d [N_NUM];
  logic             xfer_c;

`ifdef CARREGADOR_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              erro_q, erro_d;
`endif

  // Handshake only exists while collecting; in_ready is decoded from the state register.
  assign xfer_c = in_valid && (state_q == COLETA);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    vals_d  = vals_q;
`ifdef CARREGADOR_TIMEOUT_EN
    idle_d  = '0;
    erro_d  = 1'b0;
`endif
    unique case (state_q)
      COLETA: begin
        if (xfer_c) begin
          vals_d[cnt_q] = in_data;
          if (cnt_q == '0) begin
            dir_d = ordem_i;
          end
          if (cnt_q == CNT_LAST) begin
            state_d = CHEIO;
            cnt_d   = '0;
          end else begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
          end
        end
      end
      CHEIO: begin
        if (out_ack) begin
          state_d = COLETA;
        end
      end
      default: state_d = COLETA;
    endcase
`ifdef CARREGADOR_TIMEOUT_EN
    // Abandon a stalled partial batch; values stay until overwritten.
    if ((state_q == COLETA) && (cnt_q != '0) && !xfer_c) begin
      if (idle_q == IDLE_LAST) begin
        cnt_d  = '0;
        erro_d = 1'b1;
      end else begin
        idle_d = IDLE_W'(idle_q + 1'b1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLETA;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      for (int i = 0; i < int'(N_NUM); i++) begin
        vals_q[i] <= '0;
      end
`ifdef CARREGADOR_TIMEOUT_EN
      idle_q  <= '0;
      erro_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      vals_q  <= vals_d;
`ifdef CARREGADOR_TIMEOUT_EN
      idle_q  <= idle_d;
      erro_q  <= erro_d;
`endif
    end
  end

  assign in_ready        = (state_q == COLETA);
  assign ena             = (state_q == CHEIO);
  assign cresc_ou_decres = dir_q;
  assign n1_n            = vals_q[0];
  assign n2_n            = vals_q[1];
  assign n3_n            = vals_q[2];
  assign n4_n            = vals_q[3];
  assign n5_n            = vals_q[4];
  assign n6_n            = vals_q[5];
  assign n7_n            = vals_q[6];
  assign n8_n            = vals_q[7];

`ifdef CARREGADOR_TIMEOUT_EN
  assign erro = erro_q;
`else
  assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_carregador_8_num.sv
// Directed self-checking bench for carregador_8_num with a batch scoreboard.
module tb_carregador_8_num;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       ordem_i = 1'b0;
  logic       out_ack = 1'b0;
  logic       in_ready, ena, cresc_ou_decres, erro;
  logic [7:0] n1_n, n2_n, n3_n, n4_n, n5_n, n6_n, n7_n, n8_n;

  carregador_8_num dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .ordem_i         (ordem_i),
    .out_ack         (out_ack),
    .ena             (ena),
    .cresc_ou_decres (cresc_ou_decres),
    .n1_n            (n1_n),
    .n2_n            (n2_n),
    .n3_n            (n3_n),
    .n4_n            (n4_n),
    .n5_n            (n5_n),
    .n6_n            (n6_n),
    .n7_n            (n7_n),
    .n8_n            (n8_n),
    .erro            (erro)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] vals;
    logic        dir;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          xfer_cnt = 0;
  logic [63:0] mdl_vals = '0;
  int          mdl_cnt = 0;
  logic        mdl_dir = 1'b0;
  logic [63:0] dut_vals;

  assign dut_vals = {n1_n, n2_n, n3_n, n4_n, n5_n, n6_n, n7_n, n8_n};

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) xfer_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one byte; the model records it once the handshake edge has passed.
  task automatic send_byte(input logic [7:0] d, input logic o);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    ordem_i  = o;
    out_ack  = 1'b0;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) chk("send_ready_timeout", 64'(w), 64'd0);
    @(posedge clk);
    if (mdl_cnt == 0) mdl_dir = o;
    mdl_vals = {mdl_vals[55:0], d};
    mdl_cnt++;
    if (mdl_cnt == 8) begin
      sb_q.push_back('{vals: mdl_vals, dir: mdl_dir});
      mdl_cnt = 0;
    end
  endtask

  task automatic check_batch(input string tag);
    exp_t e;
    @(negedge clk);
    chk({tag, "_ena"}, 64'(ena), 64'd1);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_vals"}, dut_vals, e.vals);
      chk({tag, "_dir"}, 64'(cresc_ou_decres), 64'(e.dir));
    end
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    out_ack  = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    chk({tag, "_ack_ena"}, 64'(ena), 64'd0);
    chk({tag, "_ack_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int base;
    int pulses;
    int ena_bad;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_vals", dut_vals, 64'd0);
    chk("rst_ena", 64'(ena), 64'd0);
    chk("rst_erro", 64'(erro), 64'd0);
    chk("rst_dir", 64'(cresc_ou_decres), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_ena", 64'(ena), 64'd0);

    // Bytes 8..1 back-to-back, ascending direction
    for (int i = 8; i >= 1; i--) send_byte(8'(i), 1'b0);
    check_batch("t1");

    // Full batch held with in_valid high; nothing must be absorbed
    base = xfer_cnt;
    in_data = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_hold_vals", dut_vals, 64'h0807060504030201);
      chk("t2_hold_ena", 64'(ena), 64'd1);
    end
    chk("t2_no_xfer", 64'(xfer_cnt - base), 64'd0);
    @(negedge clk);
    out_ack = 1'b1;
    in_data = 8'h55;
    @(negedge clk);
    out_ack  = 1'b0;
    in_valid = 1'b0;
    chk("t2_ack_ena", 64'(ena), 64'd0);
    chk("t2_ack_ready", 64'(in_ready), 64'd1);
    chk("t2_ack_no_xfer", 64'(xfer_cnt - base), 64'd0);
    chk("t2_retain", dut_vals, 64'h0807060504030201);

    // Direction latched from first byte only, valid toggling, stray ack in COLETA
    base = xfer_cnt;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'd7, (i == 0));
      if (i < 7) begin
        @(negedge clk);
        in_valid = 1'b0;
        out_ack  = (i == 1);
      end
    end
    check_batch("t3");
    for (int i = 0; i < 6; i++) begin
      in_valid = (i % 2 == 0);
      @(negedge clk);
    end
    chk("t3_xfers", 64'(xfer_cnt - base), 64'd8);
    chk("t3_stable_ena", 64'(ena), 64'd1);
    do_ack("t3");

    // Reset after 5 transfers discards the partial batch
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("t4_rst_vals", dut_vals, 64'd0);
    chk("t4_rst_dir", 64'(cresc_ou_decres), 64'd0);
    chk("t4_rst_ena", 64'(ena), 64'd0);
    mdl_cnt  = 0;
    mdl_vals = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    check_batch("t4");
    do_ack("t4");

    // Partial batch followed by a long idle period
    for (int i = 0; i < 3; i++) send_byte(8'(8'h21 + i), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    pulses  = 0;
    ena_bad = 0;
    for (int i = 0; i < 260; i++) begin
      if (erro === 1'b1) pulses++;
      if (ena !== 1'b0) ena_bad++;
      @(negedge clk);
    end
    chk("t5_ena_low", 64'(ena_bad), 64'd0);
`ifdef CARREGADOR_TIMEOUT_EN
    chk("t5_erro_pulses", 64'(pulses), 64'd1);
    mdl_cnt  = 0;
    mdl_vals = '0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h31 + i), 1'b1);
    check_batch("t5_fresh");
`else
    chk("t5_erro_pulses", 64'(pulses), 64'd0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h24 + i), 1'b1);
    check_batch("t5_complete");
`endif
    do_ack("t5");

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
